// File: rtl/lab3_seg7_pkg.sv
// Shared seven-segment definitions for the lab display blocks.
//   SEG_TABLE : active-low segment patterns for hex digits 0-F
//               (bit0=a .. bit6=g, bit7=dp; dp is always off).
//   SEG_BLANK : all segments off.
//   blink_state_t : states of the per-display blink FSM.
package lab3_seg7_pkg;

  localparam logic [0:15][7:0] SEG_TABLE = {
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLINK = 1'b1
  } blink_state_t;

endpackage

// File: rtl/lab3_seg7_decode.sv
// Combinational hex-digit to seven-segment decoder.
//   value : 4-bit digit
//   seg   : active-low segment pattern, dp always off
module lab3_seg7_decode
  import lab3_seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_TABLE[value];
  end

endmodule

// File: rtl/lab3_seg7_history.sv
// Six-digit history display. Each time the input nibble changes, the new value
// is pushed onto hex0 and older values scroll toward hex5; the newest digit
// then blinks for a short burst.
//   clk       : clock, rising edge
//   reset_n   : synchronous active-low reset
//   in_value  : nibble from the upstream PIO
//   clear     : synchronous history clear, active-high
//   hex0..5   : active-low segment outputs, hex0 is the newest digit
module lab3_seg7_history
  import lab3_seg7_pkg::*;
#(
  parameter int unsigned BLINK_HALF    = 25000000,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] in_value,
  input  logic       clear,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5
);

  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned TOG_W = $clog2(BLINK_TOGGLES + 1);

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [TOG_W-1:0] TOG_LOAD    = TOG_W'(BLINK_TOGGLES);
  localparam logic [TOG_W-1:0] TOG_ONE     = TOG_W'(1);

  logic [3:0]       prev_q;
  logic             change;
  logic [5:0][3:0]  digit;
  logic [2:0]       depth;

  blink_state_t     state, state_next;
  logic             phase, phase_next;
  logic [CNT_W-1:0] half_cnt, half_next;
  logic [TOG_W-1:0] tog_left, tog_next;
  logic             blank0;

  logic [7:0]       seg [6];

  always_comb begin
    change = (in_value != prev_q) && !clear;
  end

  // History shift register and fill depth
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= '0;
      digit  <= '0;
      depth  <= '0;
    end else begin
      prev_q <= in_value;
      if (clear) begin
        digit <= '0;
        depth <= '0;
      end else if (change) begin
        digit <= {digit[4:0], in_value};
        if (depth != 3'd6) depth <= depth + 3'd1;
      end
    end
  end

  // Blink FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      phase    <= 1'b1;
      half_cnt <= '0;
      tog_left <= '0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      half_cnt <= half_next;
      tog_left <= tog_next;
    end
  end

  // Blink FSM: next state. A change always (re)starts a visible half-period.
  always_comb begin
    state_next = state;
    phase_next = phase;
    half_next  = half_cnt;
    tog_next   = tog_left;
    if (clear) begin
      state_next = ST_IDLE;
      phase_next = 1'b1;
      half_next  = '0;
      tog_next   = '0;
    end else if (change) begin
      state_next = ST_BLINK;
      phase_next = 1'b1;
      half_next  = HALF_RELOAD;
      tog_next   = TOG_LOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          phase_next = 1'b1;
        end
        ST_BLINK: begin
          if (half_cnt == '0) begin
            half_next = HALF_RELOAD;
            if (tog_left <= TOG_ONE) begin
              // Last toggle: leave the burst visible regardless of parity
              state_next = ST_IDLE;
              phase_next = 1'b1;
              tog_next   = '0;
            end else begin
              phase_next = ~phase;
              tog_next   = tog_left - TOG_ONE;
            end
          end else begin
            half_next = half_cnt - CNT_ONE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          phase_next = 1'b1;
        end
      endcase
    end
  end

  // Blink FSM: output
  always_comb begin
    blank0 = (state == ST_BLINK) && !phase;
  end

  for (genvar g = 0; g < 6; g++) begin : g_dec
    lab3_seg7_decode u_dec (
      .value (digit[g]),
      .seg   (seg[g])
    );
  end

  always_comb begin
    hex0 = ((depth > 3'd0) && !blank0) ? seg[0] : SEG_BLANK;
    hex1 = (depth > 3'd1) ? seg[1] : SEG_BLANK;
    hex2 = (depth > 3'd2) ? seg[2] : SEG_BLANK;
    hex3 = (depth > 3'd3) ? seg[3] : SEG_BLANK;
    hex4 = (depth > 3'd4) ? seg[4] : SEG_BLANK;
    hex5 = (depth > 3'd5) ? seg[5] : SEG_BLANK;
  end

endmodule

// File: tb/tb_lab3_seg7_history.sv
// Directed bench for lab3_seg7_history with a short blink (4-cycle halves,
// two toggles per burst).
module tb_lab3_seg7_history;

  localparam int unsigned HALF = 4;
  localparam int unsigned TOG  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic [3:0] in_value;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [7:0] hx [6];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab3_seg7_history #(
    .BLINK_HALF    (HALF),
    .BLINK_TOGGLES (TOG)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_value (in_value),
    .clear    (clear),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5)
  );

  always_comb begin
    hx[0] = hex0; hx[1] = hex1; hx[2] = hex2;
    hx[3] = hex3; hx[4] = hex4; hx[5] = hex5;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_value = 4'h0;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (hx[i] !== 8'hFF) begin
        bad++;
        $display("FAIL reset_hex%0d got=%h want=ff", i, hx[i]);
      end
    end
    reset_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (hx[i] !== 8'hFF) begin
        bad++;
        $display("FAIL post_reset_hex%0d got=%h want=ff", i, hx[i]);
      end
    end
  endtask

  task automatic test_first_blink();
    logic [7:0] exp;
    in_value = 4'h5;
    tick();
    total++;
    if (hex0 !== 8'h92) begin
      bad++;
      $display("FAIL first_hex0 got=%h want=92", hex0);
    end
    for (int i = 1; i < 6; i++) begin
      total++;
      if (hx[i] !== 8'hFF) begin
        bad++;
        $display("FAIL first_hex%0d got=%h want=ff", i, hx[i]);
      end
    end
    for (int c = 1; c < 12; c++) begin
      tick();
      exp = (c >= 4 && c < 8) ? 8'hFF : 8'h92;
      total++;
      if (hex0 !== exp) begin
        bad++;
        $display("FAIL blink_c%0d hex0 got=%h want=%h", c, hex0, exp);
      end
    end
  endtask

  task automatic test_history();
    logic [7:0] want [6];
    in_value = 4'h1;
    tick();
    total++;
    if (hex0 !== 8'hF9 || hex1 !== 8'h92 || hex2 !== 8'hFF) begin
      bad++;
      $display("FAIL hist_step1 got=%h_%h_%h want=ff_92_f9", hex2, hex1, hex0);
    end
    repeat (9) tick();
    for (int v = 2; v <= 7; v++) begin
      in_value = 4'(v);
      repeat (10) tick();
    end
    want = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4};
    for (int i = 0; i < 6; i++) begin
      total++;
      if (hx[i] !== want[i]) begin
        bad++;
        $display("FAIL hist_hex%0d got=%h want=%h", i, hx[i], want[i]);
      end
    end
  endtask

  task automatic test_clear();
    in_value = 4'h3;
    tick();
    total++;
    if (hex0 !== 8'hB0 || hex1 !== 8'hF8 || hex5 !== 8'hB0) begin
      bad++;
      $display("FAIL pre_clear got=%h_%h_%h want=b0_f8_b0", hex5, hex1, hex0);
    end
    repeat (9) tick();
    in_value = 4'h9;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (hx[i] !== 8'hFF) begin
        bad++;
        $display("FAIL clear_hex%0d got=%h want=ff", i, hx[i]);
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (hex0 !== 8'hFF || hex1 !== 8'hFF) begin
        bad++;
        $display("FAIL hold_after_clear_c%0d got=%h_%h want=ff_ff", c, hex1, hex0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    in_value = 4'h8;
    tick();
    total++;
    if (hex0 !== 8'h80 || hex1 !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_first got=%h_%h want=ff_80", hex1, hex0);
    end
    repeat (2) tick();
    in_value = 4'hA;
    tick();
    total++;
    if (hex0 !== 8'h88 || hex1 !== 8'h80) begin
      bad++;
      $display("FAIL b2b_second got=%h_%h want=80_88", hex1, hex0);
    end
    for (int c = 1; c < 12; c++) begin
      tick();
      exp = (c >= 4 && c < 8) ? 8'hFF : 8'h88;
      total++;
      if (hex0 !== exp) begin
        bad++;
        $display("FAIL restart_c%0d hex0 got=%h want=%h", c, hex0, exp);
      end
      total++;
      if (hex1 !== 8'h80) begin
        bad++;
        $display("FAIL restart_c%0d hex1 got=%h want=80", c, hex1);
      end
    end
  endtask

  task automatic test_reset_mid_blink();
    logic [7:0] exp;
    in_value = 4'hB;
    tick();
    total++;
    if (hex0 !== 8'h83 || hex2 !== 8'h80) begin
      bad++;
      $display("FAIL mid_start got=%h_%h want=80_83", hex2, hex0);
    end
    repeat (4) tick();
    total++;
    if (hex0 !== 8'hFF || hex1 !== 8'h88) begin
      bad++;
      $display("FAIL mid_blank got=%h_%h want=88_ff", hex1, hex0);
    end
    reset_n  = 1'b0;
    clear    = 1'b1;
    in_value = 4'h0;
    tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (hx[i] !== 8'hFF) begin
        bad++;
        $display("FAIL mid_reset_hex%0d got=%h want=ff", i, hx[i]);
      end
    end
    reset_n = 1'b1;
    clear   = 1'b0;
    repeat (2) tick();
    total++;
    if (hex0 !== 8'hFF) begin
      bad++;
      $display("FAIL after_reset hex0 got=%h want=ff", hex0);
    end
    in_value = 4'hC;
    tick();
    total++;
    if (hex0 !== 8'hC6 || hex1 !== 8'hFF) begin
      bad++;
      $display("FAIL reblink_start got=%h_%h want=ff_c6", hex1, hex0);
    end
    for (int c = 1; c < 12; c++) begin
      tick();
      exp = (c >= 4 && c < 8) ? 8'hFF : 8'hC6;
      total++;
      if (hex0 !== exp) begin
        bad++;
        $display("FAIL reblink_c%0d hex0 got=%h want=%h", c, hex0, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_blink();
    test_history();
    test_clear();
    test_back_to_back();
    test_reset_mid_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab3_seg7_history.md
LAB3_SEG7_HISTORY -- requirements
Module: lab3_seg7_history

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 25000000; cycles per blink half-period (0.5 s at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter BLINK_TOGGLES, default 6; number of visible/blank toggles per blink burst; legal range >= 1.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_value  input  4  nibble from the upstream PIO out_port, synchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous history clear, active-high.
REQ-007 SHALL have ports hex0 to hex5  output  8 each  active-low segments: bit0=a through bit6=g, bit7=dp. hex0 shows the newest digit.

Function
REQ-008 SHALL register in_value into prev_q on every edge.
REQ-009 SHALL raise change on any edge where in_value != prev_q and clear=0.
REQ-010 On change, SHALL shift digit[4:0] into digit[5:1] and load in_value into digit[0], all on the same edge. The old digit[5] SHALL be discarded.
REQ-011 SHALL keep depth (0..6) and increment it on each change. Depth SHALL saturate at 6.
REQ-012 Digit i SHALL drive hexi via the decoder when i < depth; otherwise hexi SHALL be 8'hFF (blank).
REQ-013 Decode (0-F), SHALL be: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. The dp bit SHALL always be 1.
REQ-014 hex outputs SHALL be combinational from the registers. A change sampled at edge k SHALL be visible immediately after edge k (latency 0 cycles after the sampling edge).
REQ-015 Blink FSM SHALL have two states:
 - IDLE: hex0 normal.
 - BLINK: hex0 is forced to 8'hFF while phase=0.
REQ-016 On change, the FSM SHALL enter BLINK (or restart it if already in BLINK) with phase=1, half-counter=BLINK_HALF-1 and toggles_left=BLINK_TOGGLES.
REQ-017 In BLINK, the half-counter SHALL decrement each cycle. At 0 it SHALL reload BLINK_HALF-1, invert phase and decrement toggles_left. When toggles_left reaches 0, the FSM SHALL go to IDLE with phase=1.
REQ-018 BLINK_TOGGLES SHALL be even by convention so that the burst ends visible. The FSM SHALL force phase=1 in IDLE regardless.
REQ-019 When clear=1, on that edge the block SHALL:
 - set depth to 0 and all digits to 0;
 - put the FSM in IDLE;
 - still update prev_q, so the value present during clear does not generate a change afterward.
REQ-020 Simultaneous clear and in_value change: clear SHALL win and no shift SHALL occur.
REQ-021 hex1..hex5 SHALL never blink.

Reset
REQ-022 When reset_n=0 at an edge, the block SHALL set prev_q=0, digits=0, depth=0, FSM=IDLE, phase=1 and counters=0.
REQ-023 After reset, all hex outputs SHALL read 8'hFF. The first change SHALL occur only when in_value != 0.
REQ-024 Reset mid-blink SHALL abort the burst with no residual blanking. reset_n SHALL take priority over clear.

Structure
REQ-025 A shared package lab3_seg7_pkg SHALL hold the following, for reuse by any other display block in the lab:
 - the 16-entry segment constant table;
 - the SEG_BLANK (8'hFF) constant;
 - the blink-state enum.
REQ-026 Decoding SHALL be in one combinational sub-module, lab3_seg7_decode (4-bit in, 8-bit out), instantiated six times.
REQ-027 The blink counter width SHALL be derived from BLINK_HALF, with no fixed widths.

Verification (sim with BLINK_HALF=4, BLINK_TOGGLES=2)
REQ-028 Reset held 3 cycles with in_value=0 -> all hex=FF, depth=0, and no change after release.
REQ-029 in_value 0->5 -> after that edge: hex0=92, hex1..5=FF. hex0 visible 4 cycles, FF 4 cycles, then 92 steady.
REQ-030 Sequence 1,2,3,4,5,6,7, each held 10 cycles -> hex5..hex0 = F9? no: A4 B0 99 92 82 F8 (digit 1 dropped), depth=6.
REQ-031 clear=1 in the same cycle in_value changes 3->9 -> all hex=FF, depth=0. Holding 9 afterward causes no shift.
REQ-032 Change again 2 cycles into a blink -> burst restarts: hex0 visible 4 full cycles from the new edge.
REQ-033 reset_n=0 during blank phase -> next cycle all hex=FF and FSM=IDLE. A new value after release blinks normally.
